// File: rtl/bus_rx_8bit.sv
// bus_rx_8bit: receiver for a tri-state shared bus. Strobed words are captured
// into a first-word-fall-through buffer. The block gives back-pressure and
// keeps sticky error flags for overflow and for a strobe on an undriven bus.
// Optional feature: define BUS_RX_PARITY_EN to add even-parity checking
// (bus_parity input, sticky parity_err output).
module bus_rx_8bit #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         bus_data,
    input  logic                          bus_en,
    input  logic                          bus_strobe,
    output logic                          bus_busy,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          float_err,
`ifdef BUS_RX_PARITY_EN
    input  logic                          bus_parity,
    output logic                          parity_err,
`endif
    input  logic                          clr_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LEVEL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BUSY_LEVEL = CW'(FIFO_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  capture;
    logic                  pop;
    logic                  full;
    logic                  accept;
    logic                  overflow_evt;
    logic                  float_evt;

    assign capture      = bus_strobe & bus_en;
    assign rx_valid     = (count != '0);
    assign pop          = rx_valid & rx_ready;
    assign full         = (count == FULL_LEVEL);
    // A full buffer still accepts when the head leaves on the same edge:
    // the write lands in the slot being vacated by the pop.
    assign accept       = capture & (~full | pop);
    assign overflow_evt = capture & full & ~pop;
    assign float_evt    = bus_strobe & ~bus_en;

    assign fifo_count = count;
    assign bus_busy   = (count >= BUSY_LEVEL);
    // Head word falls through; forced to zero when empty so reset clears it.
    assign rx_data    = rx_valid ? mem[rd_ptr] : '0;

    // Buffer storage: write the bus word at the tail on every accepted capture.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= bus_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally as depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags: a new event wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            float_err <= 1'b0;
        end else begin
            if (overflow_evt) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (float_evt) begin
                float_err <= 1'b1;
            end else if (clr_err) begin
                float_err <= 1'b0;
            end
        end
    end

`ifdef BUS_RX_PARITY_EN
    logic parity_evt;

    // Even parity: data bits plus parity bit must hold an even number of ones.
    assign parity_evt = capture & (^{bus_data, bus_parity});

    // Sticky parity error; the word itself is stored regardless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (parity_evt) begin
            parity_err <= 1'b1;
        end else if (clr_err) begin
            parity_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_bus_rx_8bit.sv
// Testbench for bus_rx_8bit: directed stimulus, queue-based reference model,
// per-cycle comparison plus literal spot checks.
module tb_bus_rx_8bit;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] bus_data;
    logic          bus_en;
    logic          bus_strobe;
    logic          bus_busy;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          float_err;
    logic          clr_err;
`ifdef BUS_RX_PARITY_EN
    logic          bus_parity;
    logic          parity_err;
`endif

    int checks   = 0;
    int failures = 0;

    bus_rx_8bit #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_data   (bus_data),
        .bus_en     (bus_en),
        .bus_strobe (bus_strobe),
        .bus_busy   (bus_busy),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .float_err  (float_err),
`ifdef BUS_RX_PARITY_EN
        .bus_parity (bus_parity),
        .parity_err (parity_err),
`endif
        .clr_err    (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words in a queue, sticky flags as bits.
    logic [DW-1:0] q[$];
    logic          m_ovf;
    logic          m_float;
    logic          m_perr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ovf   = 1'b0;
            m_float = 1'b0;
            m_perr  = 1'b0;
        end else begin
            if (clr_err) begin
                m_ovf   = 1'b0;
                m_float = 1'b0;
                m_perr  = 1'b0;
            end
            if (rx_ready && q.size() != 0) begin
                void'(q.pop_front());
            end
            if (bus_strobe && !bus_en) begin
                m_float = 1'b1;
            end
            if (bus_strobe && bus_en) begin
`ifdef BUS_RX_PARITY_EN
                if ((^bus_data) != bus_parity) m_perr = 1'b1;
`endif
                if (q.size() < DEPTH) q.push_back(bus_data);
                else                  m_ovf = 1'b1;
            end
        end
    end

    // Per-cycle comparison on the falling edge, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_valid", rx_valid, q.size() != 0);
        chk("cyc_count", fifo_count, q.size());
        chk("cyc_busy", bus_busy, q.size() >= DEPTH - 1);
        chk("cyc_overflow", overflow, m_ovf);
        chk("cyc_float", float_err, m_float);
`ifdef BUS_RX_PARITY_EN
        chk("cyc_parity", parity_err, m_perr);
`endif
        if (q.size() != 0) chk("cyc_data", rx_data, q[0]);
    end

    // Drive one cycle of inputs mid-low-phase, return just after the next rising edge.
    task automatic step(input logic s, input logic e, input logic [DW-1:0] d,
                        input logic r, input logic c);
        @(negedge clk);
        #1;
        bus_strobe = s;
        bus_en     = e;
        bus_data   = d;
        rx_ready   = r;
        clr_err    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    endtask

    task automatic drain_one(input logic [DW-1:0] exp_head, input string name);
        chk(name, rx_data, exp_head);
        step(1'b0, 1'b1, '0, 1'b1, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        bus_data   = '0;
        bus_en     = 1'b0;
        bus_strobe = 1'b0;
        rx_ready   = 1'b0;
        clr_err    = 1'b0;
`ifdef BUS_RX_PARITY_EN
        bus_parity = 1'b0;
`endif
        #23;
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_count", fifo_count, 0);
        chk("rst_busy", bus_busy, 1'b0);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_float", float_err, 1'b0);
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Single word with 1-cycle latency.
        step(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        chk("single_valid", rx_valid, 1'b1);
        chk("single_data", rx_data, 8'hA5);
        chk("single_count", fifo_count, 1);
        drain_one(8'hA5, "single_read");
        chk("single_empty", rx_valid, 1'b0);

        // Back-to-back burst, busy from count 3.
        step(1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
        chk("burst_busy_c2", bus_busy, 1'b0);
        step(1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
        chk("burst_busy_c3", bus_busy, 1'b1);
        step(1'b1, 1'b1, 8'h04, 1'b0, 1'b0);
        chk("burst_count4", fifo_count, 4);

        // Overflow while full, then capture+pop while full.
        step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_head", rx_data, 8'h01);
        step(1'b0, 1'b1, '0, 1'b0, 1'b1);
        chk("ovf_clr", overflow, 1'b0);
        step(1'b1, 1'b1, 8'h66, 1'b1, 1'b0);
        chk("fullpop_count", fifo_count, 4);
        chk("fullpop_noovf", overflow, 1'b0);
        drain_one(8'h02, "drain_2");
        drain_one(8'h03, "drain_3");
        drain_one(8'h04, "drain_4");
        drain_one(8'h66, "drain_66");
        chk("drain_empty", rx_valid, 1'b0);
        step(1'b0, 1'b1, '0, 1'b1, 1'b0);
        chk("ready_empty_count", fifo_count, 0);

        // Strobe on undriven bus; clear; set wins over coincident clear.
        step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
        chk("float_set", float_err, 1'b1);
        chk("float_count", fifo_count, 0);
        step(1'b0, 1'b1, '0, 1'b0, 1'b1);
        chk("float_clr", float_err, 1'b0);
        step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b1);
        chk("float_set_wins", float_err, 1'b1);
        step(1'b0, 1'b1, '0, 1'b0, 1'b1);

        // Asynchronous reset mid-burst.
        step(1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h12, 1'b0, 1'b0);
        chk("pre_rst_count", fifo_count, 3);
        bus_strobe = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", fifo_count, 0);
        chk("arst_valid", rx_valid, 1'b0);
        chk("arst_data", rx_data, 8'h00);
        chk("arst_busy", bus_busy, 1'b0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        step(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        chk("post_rst_data", rx_data, 8'h3C);
        chk("post_rst_count", fifo_count, 1);
        drain_one(8'h3C, "post_rst_read");

        // Wrap-around traffic with simultaneous capture and pop.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
        end
        idle();
        step(1'b0, 1'b1, '0, 1'b1, 1'b0);

`ifdef BUS_RX_PARITY_EN
        bus_parity = 1'b0;
        step(1'b1, 1'b1, 8'h07, 1'b0, 1'b0);
        chk("par_err_set", parity_err, 1'b1);
        chk("par_stored", rx_data, 8'h07);
        step(1'b0, 1'b1, '0, 1'b0, 1'b1);
        chk("par_clr", parity_err, 1'b0);
        step(1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
        chk("par_ok", parity_err, 1'b0);
        chk("par_count", fifo_count, 2);
`endif

        idle();
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_rx_8bit.md
BUS_RX_8BIT -- requirements
Module: bus_rx_8bit

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of the bus word and the read word.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two, at least 2, SHALL set the receive buffer depth in words.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 bus_data  input  DATA_WIDTH  shared bus lines, driven by the tri-state transmitter.
REQ-006 bus_en  input  1  transmitter output enable; 1 means bus_data is driven, 0 means it is high-Z.
REQ-007 bus_strobe  input  1  word-valid qualifier from the transmitter; each sampled high cycle is one word.
REQ-008 bus_busy  output  1  back-pressure to the transmitter.
REQ-009 rx_data  output  DATA_WIDTH  head-of-buffer word.
REQ-010 rx_valid  output  1  rx_data holds a word.
REQ-011 rx_ready  input  1  consumer accepts a word.
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored words.
REQ-013 overflow  output  1  sticky: a word was dropped because the buffer was full.
REQ-014 float_err  output  1  sticky: a strobe arrived while the bus was undriven.
REQ-015 clr_err  input  1  synchronous clear of overflow and float_err.

Function
REQ-016 A capture SHALL occur on a rising edge where bus_strobe=1 and bus_en=1; bus_data is written at the buffer tail.
REQ-017 A strobe with bus_en=0 SHALL NOT write the buffer, and SHALL set float_err on that edge.
REQ-018 Back-to-back strobe cycles SHALL each capture one word, with no dead cycle between them.
REQ-019 Pop SHALL occur on a rising edge where rx_valid=1 and rx_ready=1.
REQ-020 The buffer SHALL be first-word-fall-through: a word captured at edge N into an empty buffer is on rx_data with rx_valid=1 after edge N (1-cycle latency).
REQ-021 rx_valid SHALL equal (fifo_count != 0); rx_data SHALL be stable while rx_valid=1 and rx_ready=0.
REQ-022 Capture while full with no pop SHALL drop the word, set overflow, and leave the contents and fifo_count unchanged.
REQ-023 Capture and pop on the same edge SHALL leave fifo_count unchanged, including when full; the word is accepted and overflow is not set.
REQ-024 rx_ready while empty SHALL have no effect.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 bus_busy SHALL be combinational and equal 1 when fifo_count >= FIFO_DEPTH-1, leaving one slot of skid for a strobe already in flight.
REQ-027 clr_err SHALL clear both sticky flags on the next edge.
REQ-028 If clr_err coincides with a new error event, the set SHALL win.

Reset
REQ-029 When rst_n=0, regardless of clk, the block SHALL force fifo_count=0, both pointers=0, rx_valid=0, rx_data=0, overflow=0, float_err=0 and bus_busy=0.
REQ-030 A reset asserted mid-burst SHALL discard all buffered words.
REQ-031 No capture SHALL occur on the first edge after rst_n deasserts unless bus_strobe and bus_en are both high at that edge.

Configuration
REQ-032 Macro BUS_RX_PARITY_EN SHALL compile in even-parity checking.
- Defined: adds input bus_parity (1 bit) and sticky output parity_err.
- The check SHALL run on each capture: a mismatch sets parity_err, and the word is still stored.
- clr_err SHALL clear parity_err.
- Undefined: neither port exists and behaviour is otherwise identical.

Verification
REQ-033 Reset then single word: bus_en=1, 1-cycle strobe, bus_data=8'hA5, rx_ready=0 -> after that edge rx_valid=1, rx_data=8'hA5, fifo_count=1.
REQ-034 Burst and drain: strobe 4 consecutive cycles with data 1,2,3,4, rx_ready=0 -> fifo_count=4 and bus_busy=1 from count 3; with rx_ready=1, reads return 1,2,3,4, then rx_valid=0.
REQ-035 Overflow: buffer full, fifth strobe with 8'h55 and rx_ready=0 -> overflow=1, fifo_count stays 4, 8'h55 never read; a second full strobe with rx_ready=1 on the same edge -> accepted, count stays 4, no new overflow.
REQ-036 Float: bus_en=0, strobe with bus_data=8'hFF -> float_err=1, fifo_count unchanged; clr_err pulse -> float_err=0.
REQ-037 Async reset mid-burst: rst_n low between clock edges with fifo_count=3 -> all outputs 0 immediately; after release, a strobe with 8'h3C -> rx_data=8'h3C, fifo_count=1.
REQ-038 With BUS_RX_PARITY_EN defined: bus_data=8'h07 with bus_parity=0 -> parity_err=1 and word stored; 8'h03 with bus_parity=0 -> no error.
